instruction_fetch_unit: RTL and testbench

Instruction fetch front end for the ARM-LP LEGv8 core. It supplies the instruction stream that the Controller decodes. It issues sequential word reads to instruction memory over a request/acknowledge handshake and buffers returned words with their addresses in a small FIFO. Instructions go to the Controller over a valid/ready handshake. A branch redirect from the PC logic flushes the FIFO and any in-flight fetch.

---
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: sequential word reads over req/ack, a small FIFO of
// {pc, instruction}, valid/ready to the Controller, redirect flush.
module instruction_fetch_unit #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        redirect,
   input  logic [31:0] redirectPC,
   output logic        memReq,
   output logic [31:0] memAddr,
   input  logic        memAck,
   input  logic [31:0] memData,
   output logic [31:0] instruction,
   output logic [31:0] instructionPC,
   output logic        instrValid,
   input  logic        instrReady
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      REQUEST,
      DISCARD
   } stateT;

   stateT         state;
   logic [31:0]   target;
   logic [31:0]   pendPC;
   logic [CW-1:0] count;
   logic [CW-1:0] nextCount;
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic          push;
   logic          pop;
   logic [31:0]   dataMem [DEPTH];
   logic [31:0]   pcMem   [DEPTH];

   assign target = redirectPC & ~32'h3;
   assign push = (state == REQUEST) && memAck && !redirect;
   assign pop = instrValid && instrReady;

   always_comb begin
      nextCount = count;
      if (push && !pop) begin
         nextCount = count + CW'(1);
      end else if (pop && !push) begin
         nextCount = count - CW'(1);
      end
   end

   assign instrValid = (count != '0);
   assign instruction = instrValid ? dataMem[rdPtr] : '0;
   assign instructionPC = instrValid ? pcMem[rdPtr] : '0;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state   <= IDLE;
         memReq  <= 1'b0;
         memAddr <= RESET_PC;
         pendPC  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (redirect) begin
                  memAddr <= target;
                  memReq  <= 1'b1;
                  state   <= REQUEST;
               end else if (count < FULL) begin
                  memReq <= 1'b1;
                  state  <= REQUEST;
               end
            end
            REQUEST: begin
               if (memAck) begin
                  if (redirect) begin
                     memAddr <= target;
                  end else begin
                     memAddr <= memAddr + 32'd4;
                     if (nextCount >= FULL) begin
                        memReq <= 1'b0;
                        state  <= IDLE;
                     end
                  end
               end else if (redirect) begin
                  pendPC <= target;
                  state  <= DISCARD;
               end
            end
            DISCARD: begin
               // a redirect coinciding with the ack wins over the latched one
               if (memAck) begin
                  memAddr <= redirect ? target : pendPC;
                  state   <= REQUEST;
               end else if (redirect) begin
                  pendPC <= target;
               end
            end
            default: begin
               memReq <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         count <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (redirect) begin
         count <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         count <= nextCount;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         dataMem[wrPtr] <= memData;
         pcMem[wrPtr]   <= memAddr;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle vector table plus
// wait-state, wrap and asynchronous reset sequences.
module tb_instruction_fetch_unit;

   localparam logic [31:0] W0 = 32'h8B150289;
   localparam logic [31:0] W4 = 32'h910006D6;

   typedef struct {
      logic        rst;
      logic        ack;
      logic        rdy;
      logic        rd;
      logic        ovr;
      logic [31:0] rpc;
      logic        eReq;
      logic [31:0] eAddr;
      logic        eV;
      logic [31:0] eI;
      logic [31:0] eP;
   } vecT;

   logic        clock;
   logic        resetN;
   logic        redirect;
   logic [31:0] redirectPC;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memData;
   logic [31:0] instruction;
   logic [31:0] instructionPC;
   logic        instrValid;
   logic        instrReady;
   logic        ovr;

   logic        wResetN;
   logic        wRedirect;
   logic [31:0] wRedirectPC;
   logic        wMemReq;
   logic [31:0] wMemAddr;
   logic        wMemAck;
   logic [31:0] wMemData;
   logic [31:0] wInstr;
   logic [31:0] wPC;
   logic        wValid;
   logic        wReady;

   int total = 0;
   int bad = 0;
   vecT vecs[$];

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0) return W0;
      if (a == 32'h4) return W4;
      return {16'hC0DE, a[15:0]};
   endfunction

   function automatic vecT mk(
      input logic rst, input logic ack, input logic rdy,
      input logic rd, input logic ov, input logic [31:0] rpc,
      input logic eReq, input logic [31:0] eAddr, input logic eV,
      input logic [31:0] eI, input logic [31:0] eP);
      vecT v;
      v.rst = rst; v.ack = ack; v.rdy = rdy; v.rd = rd; v.ovr = ov;
      v.rpc = rpc; v.eReq = eReq; v.eAddr = eAddr; v.eV = eV;
      v.eI = eI; v.eP = eP;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   assign memData = ovr ? 32'hDEADBEEF : memWord(memAddr);
   assign wMemData = memWord(wMemAddr);

   instruction_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
      .clock(clock), .resetN(resetN),
      .redirect(redirect), .redirectPC(redirectPC),
      .memReq(memReq), .memAddr(memAddr),
      .memAck(memAck), .memData(memData),
      .instruction(instruction), .instructionPC(instructionPC),
      .instrValid(instrValid), .instrReady(instrReady)
   );

   instruction_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFFFFFC)) dutWrap (
      .clock(clock), .resetN(wResetN),
      .redirect(wRedirect), .redirectPC(wRedirectPC),
      .memReq(wMemReq), .memAddr(wMemAddr),
      .memAck(wMemAck), .memData(wMemData),
      .instruction(wInstr), .instructionPC(wPC),
      .instrValid(wValid), .instrReady(wReady)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      resetN = 0; redirect = 0; redirectPC = 0; memAck = 0;
      instrReady = 0; ovr = 0;
      wResetN = 0; wRedirect = 0; wRedirectPC = 0; wMemAck = 1; wReady = 1;

      // reset, sequential stream
      vecs.push_back(mk(0,0,0,0,0,0,        0,32'h0,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h0,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h4,1,W0,32'h0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h8,1,W4,32'h4));
      // backpressure
      vecs.push_back(mk(0,0,0,0,0,0,        0,32'h0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,        1,32'h0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,        1,32'h4,1,W0,32'h0));
      vecs.push_back(mk(1,1,0,0,0,0,        0,32'h8,1,W0,32'h0));
      vecs.push_back(mk(1,1,0,0,0,0,        0,32'h8,1,W0,32'h0));
      vecs.push_back(mk(1,1,1,0,0,0,        0,32'h8,1,W4,32'h4));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h8,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'hC,1,32'hC0DE0008,32'h8));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h10,1,32'hC0DE000C,32'hC));
      // redirect during outstanding read
      vecs.push_back(mk(0,0,0,0,0,0,        0,32'h0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,        1,32'h0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,        1,32'h4,1,W0,32'h0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h8,1,W4,32'h4));
      vecs.push_back(mk(1,0,0,0,0,0,        1,32'h8,1,W4,32'h4));
      vecs.push_back(mk(1,0,0,1,0,32'h100,  1,32'h8,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,        1,32'h8,0,0,0));
      vecs.push_back(mk(1,1,1,0,1,0,        1,32'h100,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h104,1,32'hC0DE0100,32'h100));
      // simultaneous ack, transfer and redirect
      vecs.push_back(mk(1,0,1,0,0,0,        1,32'h104,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,        1,32'h108,1,32'hC0DE0104,32'h104));
      vecs.push_back(mk(1,1,1,1,0,32'h203,  1,32'h200,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h204,1,32'hC0DE0200,32'h200));
      // repeated redirect while discarding
      vecs.push_back(mk(1,0,1,0,0,0,        1,32'h204,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,32'h300,  1,32'h204,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,32'h400,  1,32'h204,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h400,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h404,1,32'hC0DE0400,32'h400));
      // redirect from IDLE
      vecs.push_back(mk(1,1,0,0,0,0,        0,32'h408,1,32'hC0DE0400,32'h400));
      vecs.push_back(mk(1,0,0,1,0,32'h500,  1,32'h500,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,        1,32'h504,1,32'hC0DE0500,32'h500));

      chk("pre_reset_req", {31'b0, memReq}, 32'h0);
      chk("pre_reset_valid", {31'b0, instrValid}, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         resetN = vecs[i].rst;
         memAck = vecs[i].ack;
         instrReady = vecs[i].rdy;
         redirect = vecs[i].rd;
         redirectPC = vecs[i].rpc;
         ovr = vecs[i].ovr;
         @(posedge clock);
         #1;
         chk($sformatf("row%0d_req", i), {31'b0, memReq}, {31'b0, vecs[i].eReq});
         chk($sformatf("row%0d_addr", i), memAddr, vecs[i].eAddr);
         chk($sformatf("row%0d_valid", i), {31'b0, instrValid}, {31'b0, vecs[i].eV});
         if (vecs[i].eV || !vecs[i].rst) begin
            chk($sformatf("row%0d_instr", i), instruction, vecs[i].eI);
            chk($sformatf("row%0d_pc", i), instructionPC, vecs[i].eP);
         end
      end

      // wait states: ack three cycles after each request
      resetN = 0; memAck = 0; instrReady = 1; redirect = 0; ovr = 0;
      @(posedge clock);
      #1;
      resetN = 1;
      @(posedge clock);
      #1;
      chk("ws_first_req", {31'b0, memReq}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("ws%0d_%0d_req", k, c), {31'b0, memReq}, 32'h1);
            chk($sformatf("ws%0d_%0d_addr", k, c), memAddr, 32'(4 * k));
            chk($sformatf("ws%0d_%0d_valid", k, c), {31'b0, instrValid}, 32'h0);
         end
         memAck = 1;
         @(posedge clock);
         #1;
         memAck = 0;
         chk($sformatf("ws%0d_valid", k), {31'b0, instrValid}, 32'h1);
         chk($sformatf("ws%0d_pc", k), instructionPC, 32'(4 * k));
         chk($sformatf("ws%0d_instr", k), instruction, memWord(32'(4 * k)));
         chk($sformatf("ws%0d_next", k), memAddr, 32'(4 * k + 4));
      end

      // address wrap, then asynchronous reset mid-request
      wResetN = 1;
      @(posedge clock);
      #1;
      chk("wrap_req", {31'b0, wMemReq}, 32'h1);
      chk("wrap_addr0", wMemAddr, 32'hFFFFFFFC);
      @(posedge clock);
      #1;
      chk("wrap_addr1", wMemAddr, 32'h0);
      chk("wrap_valid", {31'b0, wValid}, 32'h1);
      chk("wrap_pc", wPC, 32'hFFFFFFFC);
      chk("wrap_instr", wInstr, 32'hC0DEFFFC);
      wMemAck = 0;
      wReady = 0;
      @(posedge clock);
      #1;
      chk("wrap_pending_req", {31'b0, wMemReq}, 32'h1);
      #3;
      wResetN = 0;
      #1;
      chk("async_req", {31'b0, wMemReq}, 32'h0);
      chk("async_valid", {31'b0, wValid}, 32'h0);
      chk("async_addr", wMemAddr, 32'hFFFFFFFC);
      chk("async_instr", wInstr, 32'h0);
      @(posedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
